gpr_bank: RTL and testbench

GPR_BANK -- requirements
Module: gpr_bank

---
 rtl/gpr_bank.sv | 151 +++++++++++++++
 tb/tb_gpr_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_bank.sv
// -----------------------------------------------------------------------------
// gpr_bank -- general-purpose register bank with two combinational read ports,
// one write port, a debug read port and a one-register-per-cycle clear sweep.
//
// Parameters
//   DW        data width in bits
//   AW        address width; DEPTH = 2**AW registers
//   ZERO_REG  1: register 0 reads as zero and ignores writes
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst_n     synchronous active-low reset; starts a full clear sweep
//   ra, rb    read addresses for rd1 / rd2
//   rw, wd    write address / write data
//   we        write enable (ignored while busy or when clr is set)
//   clr       one-cycle request to zero the whole bank
//   rd1, rd2  combinational read data (forced to 0 while busy)
//   busy      high while a clear sweep is running
//   dbg_addr  debug read address
//   dbg_data  raw contents of register dbg_addr, never bypassed
//
// Build options
//   GPR_BYPASS_EN  when defined, a write in progress is forwarded to rd1/rd2
//                  in the same cycle if the addresses match.
// -----------------------------------------------------------------------------
module gpr_bank #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] rw,
    input  logic [DW-1:0] wd,
    input  logic          we,
    input  logic          clr,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned DEPTH = 2 ** AW;
    // One extra bit so the terminal count DEPTH-1 is compared without wrap.
    localparam int unsigned CW    = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [DW-1:0] mem_wdata_c;

    logic [DW-1:0] mem [DEPTH];

    // True when address a hits the hard-wired zero register.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // State and sweep counter; reset lands in CLEAR so the bank is zeroed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and storage write selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    // clr takes priority; a simultaneous write is dropped.
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (we && !is_zero(rw)) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = rw;
                    mem_wdata_c = wd;
                end
            end
            CLEAR: begin
                // One register per cycle; clr and we are ignored here.
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q[AW-1:0];
                mem_wdata_c = '0;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Storage array; no reset, the sweep provides initial values.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign busy = (state_q == CLEAR);

    // Architectural read ports.
    always_comb begin
        rd1 = mem[ra];
        rd2 = mem[rb];
`ifdef GPR_BYPASS_EN
        if ((state_q == IDLE) && we) begin
            if (rw == ra) begin
                rd1 = wd;
            end
            if (rw == rb) begin
                rd2 = wd;
            end
        end
`endif
        if (busy || is_zero(ra)) begin
            rd1 = '0;
        end
        if (busy || is_zero(rb)) begin
            rd2 = '0;
        end
    end

    // Debug port shows raw storage, even during a sweep.
    assign dbg_data = is_zero(dbg_addr) ? '0 : mem[dbg_addr];

endmodule

// File: tb/tb_gpr_bank.sv
// -----------------------------------------------------------------------------
// tb_gpr_bank -- directed scoreboard bench for gpr_bank (DW=32, AW=5).
// Stimulus pushes expected outputs tagged with the cycle they apply to; a
// monitor on the falling edge pops and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_gpr_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rw;
    logic [DW-1:0] wd;
    logic          we;
    logic          clr;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          busy;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    gpr_bank #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rb       (rb),
        .rw       (rw),
        .wd       (wd),
        .we       (we),
        .clr      (clr),
        .rd1      (rd1),
        .rd2      (rd2),
        .busy     (busy),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_RD1  = 0;
    localparam int SEL_RD2  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_DBG  = 3;

    typedef struct {
        int          id;
        int          sel;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          issued;
    int          vectors;
    int          miscompares;
    exp_t        mon_e;
    logic [31:0] mon_act;

    initial begin
        cyc         = 0;
        issued      = 0;
        vectors     = 0;
        miscompares = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sel_name(input int sel);
        case (sel)
            SEL_RD1:  return "rd1";
            SEL_RD2:  return "rd2";
            SEL_BUSY: return "busy";
            default:  return "dbg_data";
        endcase
    endfunction

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SEL_RD1:  return rd1;
            SEL_RD2:  return rd2;
            SEL_BUSY: return {31'b0, busy};
            default:  return dbg_data;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = pick(mon_e.sel);
            vectors++;
            if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
                miscompares++;
                $display("FAIL v%0d %s (cycle %0d): got %h, expected %h",
                         mon_e.id, sel_name(mon_e.sel), mon_e.cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic expect_out(input int sel, input logic [31:0] v);
        exp_t e;
        e.id  = issued;
        e.sel = sel;
        e.val = v;
        e.cyc = cyc;
        sb.push_back(e);
        issued++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we  = 1'b0;
        clr = 1'b0;
        rw  = '0;
        wd  = '0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
        we  = 1'b1;
        clr = 1'b0;
        rw  = a;
        wd  = d;
        step();
        idle_in();
    endtask

    // Expect busy=1 with rd1/rd2 forced to 0 for n cycles, then busy=0.
    task automatic expect_sweep(input int n);
        for (int k = 0; k < n; k++) begin
            expect_out(SEL_BUSY, 32'd1);
            expect_out(SEL_RD1, 32'd0);
            step();
        end
        expect_out(SEL_BUSY, 32'd0);
    endtask

    task automatic expect_all_zero();
        for (int i = 0; i < DEPTH; i++) begin
            dbg_addr = AW'(i);
            expect_out(SEL_DBG, 32'd0);
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ra       = '0;
        rb       = '0;
        dbg_addr = '0;
        idle_in();

        // Reset: one cycle low, then a DEPTH-cycle sweep.
        step();
        rst_n = 1'b1;
        ra    = 5'd9;
        rb    = 5'd9;
        expect_out(SEL_RD2, 32'd0);
        expect_sweep(DEPTH);
        step();
        expect_all_zero();

        // Write then read back; zero register ignores writes.
        write_reg(5'd5, 32'hDEADBEEF);
        ra = 5'd5;
        rb = 5'd5;
        expect_out(SEL_RD1, 32'hDEADBEEF);
        expect_out(SEL_RD2, 32'hDEADBEEF);
        step();
        write_reg(5'd0, 32'h00001234);
        ra       = 5'd0;
        dbg_addr = 5'd0;
        expect_out(SEL_RD1, 32'd0);
        expect_out(SEL_DBG, 32'd0);
        step();

        // Same-cycle write/read of register 7.
        we = 1'b1;
        rw = 5'd7;
        wd = 32'hA5A5A5A5;
        ra = 5'd7;
        rb = 5'd5;
`ifdef GPR_BYPASS_EN
        expect_out(SEL_RD1, 32'hA5A5A5A5);
`else
        expect_out(SEL_RD1, 32'd0);
`endif
        expect_out(SEL_RD2, 32'hDEADBEEF);
        step();
        idle_in();
        expect_out(SEL_RD1, 32'hA5A5A5A5);
        step();

        // Fill 1..31 with index, then clr together with a write to reg 3.
        for (int i = 1; i < DEPTH; i++) begin
            write_reg(AW'(i), 32'(i));
        end
        ra = 5'd3;
        rb = 5'd31;
        expect_out(SEL_RD1, 32'd3);
        expect_out(SEL_RD2, 32'd31);
        step();
        clr      = 1'b1;
        we       = 1'b1;
        rw       = 5'd3;
        wd       = 32'h000000FF;
        ra       = 5'd4;
        dbg_addr = 5'd3;
        expect_out(SEL_RD1, 32'd4);
        expect_out(SEL_BUSY, 32'd0);
        step();
        idle_in();
        // Raw storage visible during the sweep: reg 3 survives until cycle 4.
        for (int k = 0; k < DEPTH; k++) begin
            expect_out(SEL_BUSY, 32'd1);
            expect_out(SEL_RD1, 32'd0);
            expect_out(SEL_DBG, (k < 4) ? 32'd3 : 32'd0);
            step();
        end
        expect_out(SEL_BUSY, 32'd0);
        step();
        expect_all_zero();

        // Reset in the middle of a sweep restarts it.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            expect_out(SEL_BUSY, 32'd1);
            step();
        end
        rst_n = 1'b0;
        expect_out(SEL_BUSY, 32'd1);
        step();
        rst_n = 1'b1;
        expect_sweep(DEPTH);
        step();

        // clr during a sweep does not extend it; we is ignored while busy.
        write_reg(5'd2, 32'h00000022);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            clr = (k == 20);
            we  = (k == 25);
            rw  = 5'd2;
            wd  = 32'h00000077;
            expect_out(SEL_BUSY, 32'd1);
            step();
        end
        idle_in();
        expect_out(SEL_BUSY, 32'd0);
        dbg_addr = 5'd2;
        expect_out(SEL_DBG, 32'd0);
        step();

        step();
        if (sb.size() != 0) begin
            $display("FAIL unchecked: %0d expectations left, expected 0", sb.size());
            vectors     += sb.size();
            miscompares += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
